// File: rtl/decodificador_teclado_pkg.sv
// -----------------------------------------------------------------------------
// decodificador_teclado_pkg
//   Shared definitions for the keypad decoder and its consumers.
//   - TECLA_ENTER / TECLA_ASTERISCO : reserved key codes ('#' and '*')
//   - estado_t                      : scanner/debounce FSM states
//   - mapa_tecla()                  : 4x4 keypad map (row, col) -> key code
//   - coluna_prioritaria()          : lowest-index active-low column
//   - drive_linha()                 : active-low one-hot row drive for a row
// -----------------------------------------------------------------------------
package decodificador_teclado_pkg;

  localparam logic [3:0] TECLA_ENTER     = 4'hF;
  localparam logic [3:0] TECLA_ASTERISCO = 4'hE;

  typedef enum logic [1:0] {
    VARRER      = 2'd0,
    DEBOUNCE    = 2'd1,
    PRESSIONADA = 2'd2,
    SOLTAR      = 2'd3
  } estado_t;

  // Keypad layout:
  //   row 0: 1 2 3 A
  //   row 1: 4 5 6 B
  //   row 2: 7 8 9 C
  //   row 3: * 0 # D
  function automatic logic [3:0] mapa_tecla(input logic [1:0] linha,
                                            input logic [1:0] coluna);
    logic [3:0] codigo;
    case ({linha, coluna})
      4'b00_00: codigo = 4'h1;
      4'b00_01: codigo = 4'h2;
      4'b00_10: codigo = 4'h3;
      4'b00_11: codigo = 4'hA;
      4'b01_00: codigo = 4'h4;
      4'b01_01: codigo = 4'h5;
      4'b01_10: codigo = 4'h6;
      4'b01_11: codigo = 4'hB;
      4'b10_00: codigo = 4'h7;
      4'b10_01: codigo = 4'h8;
      4'b10_10: codigo = 4'h9;
      4'b10_11: codigo = 4'hC;
      4'b11_00: codigo = TECLA_ASTERISCO;
      4'b11_01: codigo = 4'h0;
      4'b11_10: codigo = TECLA_ENTER;
      default:  codigo = 4'hD;
    endcase
    return codigo;
  endfunction

  // Columns are active-low; when several are low the lowest index wins.
  function automatic logic [1:0] coluna_prioritaria(input logic [3:0] col_n);
    logic [1:0] coluna;
    if (!col_n[0])      coluna = 2'd0;
    else if (!col_n[1]) coluna = 2'd1;
    else if (!col_n[2]) coluna = 2'd2;
    else                coluna = 2'd3;
    return coluna;
  endfunction

  function automatic logic [3:0] drive_linha(input logic [1:0] idx);
    logic [3:0] um_quente;
    um_quente = 4'b0001 << idx;
    return ~um_quente;
  endfunction

endpackage

// File: rtl/decodificador_teclado_sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
//   Parameterized-width two-flop synchronizer for signals asynchronous to clk.
//   Ports:
//     clk  : destination clock
//     rst  : asynchronous active-high reset, loads RESET_VALUE into both stages
//     d_i  : asynchronous input bus
//     q_o  : synchronized output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sincronizador #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/decodificador_teclado.sv
// -----------------------------------------------------------------------------
// decodificador_teclado
//   Scans a 4x4 active-low membrane keypad, debounces presses and releases and
//   presents one decoded key per press.
//   Parameters:
//     SCAN_CYCLES     : dwell per row before its columns are sampled (>= 4)
//     DEBOUNCE_CYCLES : consecutive identical samples to accept press/release
//   Ports:
//     clk        : system clock
//     rst        : asynchronous active-high reset
//     col_matriz : keypad columns, active-low, asynchronous to clk
//     lin_matriz : row drive, active-low, exactly one bit low
//     key_valid  : high while the accepted key is held (incl. release debounce)
//     key_code   : code of the accepted key, held after release
// -----------------------------------------------------------------------------
module decodificador_teclado
  import decodificador_teclado_pkg::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_matriz,
  output logic [3:0] lin_matriz,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  logic [3:0]        col_s;

  estado_t           state_q;
  logic [1:0]        idx_q;
  logic [1:0]        col_q;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [3:0]        lin_q;
  logic              key_valid_q;
  logic [3:0]        key_code_q;

  // Latched column bit of the key under debounce / held (1 = released).
  logic              col_alta;

  sincronizador #(
    .WIDTH      (4),
    .RESET_VALUE(4'b1111)
  ) u_sinc_col (
    .clk (clk),
    .rst (rst),
    .d_i (col_matriz),
    .q_o (col_s)
  );

  assign col_alta = col_s[col_q];

  // idx_q doubles as the latched row: it is frozen from detection until the
  // release completes, so the driven row and the decoded row always agree.
  // Counters stop at their terminal values before any wrap can occur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= VARRER;
      idx_q       <= 2'd0;
      col_q       <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      lin_q       <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      case (state_q)
        VARRER: begin
          if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            if (col_s != 4'b1111) begin
              // Detection sample counts as the first low sample.
              col_q     <= coluna_prioritaria(col_s);
              deb_cnt_q <= DEB_ONE;
              state_q   <= DEBOUNCE;
            end else begin
              idx_q <= idx_q + 2'd1;
              lin_q <= drive_linha(idx_q + 2'd1);
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + SCAN_ONE;
          end
        end

        DEBOUNCE: begin
          if (!col_alta) begin
            if (deb_cnt_q == DEB_LAST) begin
              key_code_q  <= mapa_tecla(idx_q, col_q);
              key_valid_q <= 1'b1;
              deb_cnt_q   <= '0;
              state_q     <= PRESSIONADA;
            end else begin
              deb_cnt_q <= deb_cnt_q + DEB_ONE;
            end
          end else begin
            // Bounce: rescan the same row from a fresh dwell.
            deb_cnt_q  <= '0;
            scan_cnt_q <= '0;
            state_q    <= VARRER;
          end
        end

        PRESSIONADA: begin
          if (col_alta) begin
            deb_cnt_q <= DEB_ONE;
            state_q   <= SOLTAR;
          end
        end

        SOLTAR: begin
          if (col_alta) begin
            if (deb_cnt_q == DEB_LAST) begin
              key_valid_q <= 1'b0;
              deb_cnt_q   <= '0;
              scan_cnt_q  <= '0;
              idx_q       <= idx_q + 2'd1;
              lin_q       <= drive_linha(idx_q + 2'd1);
              state_q     <= VARRER;
            end else begin
              deb_cnt_q <= deb_cnt_q + DEB_ONE;
            end
          end else begin
            // Release glitch: key still held, key_valid untouched.
            deb_cnt_q <= '0;
            state_q   <= PRESSIONADA;
          end
        end

        default: state_q <= VARRER;
      endcase
    end
  end

  assign lin_matriz = lin_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;

endmodule

// File: tb/tb_decodificador_teclado.sv
// -----------------------------------------------------------------------------
// tb_decodificador_teclado
//   Directed bench for decodificador_teclado with SCAN_CYCLES=4,
//   DEBOUNCE_CYCLES=8 and a keypad model that shorts the driven row onto the
//   columns of the pressed keys.
// -----------------------------------------------------------------------------
module tb_decodificador_teclado;

  logic       clk;
  logic       rst;
  logic [3:0] col_matriz;
  logic [3:0] lin_matriz;
  logic       key_valid;
  logic [3:0] key_code;

  // pressed[r][c] = 1 when the key at row r, column c is held down.
  logic [3:0][3:0] pressed;

  int checks;
  int errors;

  int rise_count;
  int code_changes;
  int lin_err;
  logic       kv_prev;
  logic [3:0] code_prev;

  decodificador_teclado #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_matriz (col_matriz),
    .lin_matriz (lin_matriz),
    .key_valid  (key_valid),
    .key_code   (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a held key pulls its column low only while its row is driven.
  always_comb begin
    col_matriz = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!lin_matriz[r]) col_matriz = col_matriz & ~pressed[r];
    end
  end

  // Monitor: counts key_valid rises, flags code changes while held and any
  // row drive that is not exactly one bit low.
  initial begin
    rise_count   = 0;
    code_changes = 0;
    lin_err      = 0;
    kv_prev      = 1'b0;
    code_prev    = 4'h0;
  end

  always @(negedge clk) begin
    if (key_valid && !kv_prev) begin
      rise_count = rise_count + 1;
      $display("[%0t] key_valid rise, key_code=%h", $time, key_code);
    end
    if (key_valid && kv_prev && key_code !== code_prev) code_changes = code_changes + 1;
    if ($countones(~lin_matriz) != 1) lin_err = lin_err + 1;
    kv_prev   = key_valid;
    code_prev = key_code;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance to just after the next falling edge (outputs stable, monitor done).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait until key_valid equals lvl; n returns the number of ticks taken.
  task automatic wait_kv(input logic lvl, input int max, input string tag, output int n);
    n = 0;
    while (key_valid !== lvl && n < max) begin
      tick();
      n++;
    end
    if (key_valid !== lvl) check(tag, int'(key_valid), int'(lvl));
  endtask

  int n;
  int r0;
  int bad;
  int t3_row  [3] = '{3, 3, 3};
  int t3_col  [3] = '{2, 0, 3};
  int t3_code [3] = '{15, 14, 13};

  initial begin
    checks  = 0;
    errors  = 0;
    pressed = '0;
    rst     = 1'b1;
    ticks(3);

    // Reset state
    check("rst_lin",   int'(lin_matriz), 4'b1110);
    check("rst_valid", int'(key_valid),  0);
    check("rst_code",  int'(key_code),   0);
    rst = 1'b0;
    ticks(5);

    // 1: press '5', hold 100 cycles, release
    r0 = rise_count;
    pressed[1][1] = 1'b1;
    wait_kv(1'b1, 100, "t1_rise_timeout", n);
    check("t1_code", int'(key_code), 5);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (lin_matriz !== 4'b1101) bad++;
    end
    check("t1_lin_hold", bad, 0);
    check("t1_rises", rise_count - r0, 1);
    pressed[1][1] = 1'b0;
    wait_kv(1'b0, 40, "t1_fall_timeout", n);
    // 2 synchronizer stages + 8 consecutive high samples
    check("t1_fall_latency", n, 10);
    $display("[%0t] t1 '5' released after %0d cycles", $time, n);
    ticks(5);

    // 2: bouncing '7'
    r0 = rise_count;
    for (int i = 0; i < 30; i++) begin
      pressed[2][0] = ((i / 3) % 2 == 0);
      tick();
    end
    check("t2_no_rise_bounce", rise_count - r0, 0);
    pressed[2][0] = 1'b1;
    wait_kv(1'b1, 100, "t2_rise_timeout", n);
    check("t2_code", int'(key_code), 7);
    ticks(20);
    check("t2_rises", rise_count - r0, 1);
    pressed[2][0] = 1'b0;
    wait_kv(1'b0, 40, "t2_fall_timeout", n);
    ticks(5);

    // 3: '#', '*', 'D' as separate presses
    for (int k = 0; k < 3; k++) begin
      r0 = rise_count;
      pressed[t3_row[k]][t3_col[k]] = 1'b1;
      wait_kv(1'b1, 100, "t3_rise_timeout", n);
      check($sformatf("t3_code_%0d", k), int'(key_code), t3_code[k]);
      ticks(20);
      pressed[t3_row[k]][t3_col[k]] = 1'b0;
      wait_kv(1'b0, 40, "t3_fall_timeout", n);
      check($sformatf("t3_rises_%0d", k), rise_count - r0, 1);
      $display("[%0t] t3 key %h pressed and released", $time, t3_code[k]);
      ticks(5);
    end

    // 4: '2' and 'A' together -> lowest column wins, single rise
    r0 = rise_count;
    pressed[0][1] = 1'b1;
    pressed[0][3] = 1'b1;
    wait_kv(1'b1, 100, "t4_rise_timeout", n);
    check("t4_code", int'(key_code), 2);
    ticks(60);
    check("t4_rises", rise_count - r0, 1);
    pressed[0] = 4'b0000;
    wait_kv(1'b0, 40, "t4_fall_timeout", n);
    ticks(5);

    // 5: '9' held with a 3-cycle release glitch
    pressed[2][2] = 1'b1;
    wait_kv(1'b1, 100, "t5_rise_timeout", n);
    ticks(5);
    r0  = rise_count;
    bad = 0;
    pressed[2][2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!key_valid) bad++;
    end
    pressed[2][2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!key_valid) bad++;
    end
    check("t5_valid_low_samples", bad, 0);
    check("t5_code", int'(key_code), 9);
    check("t5_no_new_rise", rise_count - r0, 0);
    pressed[2][2] = 1'b0;
    wait_kv(1'b0, 40, "t5_fall_timeout", n);
    ticks(5);

    // 6: reset while '0' is held
    pressed[3][1] = 1'b1;
    wait_kv(1'b1, 100, "t6_rise_timeout", n);
    ticks(3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", int'(key_valid),  0);
    check("t6_rst_code",  int'(key_code),   0);
    check("t6_rst_lin",   int'(lin_matriz), 4'b1110);
    tick();
    rst = 1'b0;
    r0  = rise_count;
    wait_kv(1'b1, 100, "t6_rerise_timeout", n);
    // rows 0..2 dwell (12) + row 3 dwell with sync (4) + 7 more debounce samples
    check("t6_rerise_latency", n, 23);
    check("t6_code", int'(key_code), 0);
    check("t6_rises", rise_count - r0, 1);
    pressed[3][1] = 1'b0;
    wait_kv(1'b0, 40, "t6_fall_timeout", n);
    ticks(5);

    check("code_stable_while_valid", code_changes, 0);
    check("lin_onehot", lin_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
